// File: rtl/butterfly_pkg.sv
// rtl/butterfly_pkg.sv - shared types and defaults for the radix-2 butterfly scheduler
package butterfly_pkg;

  localparam int BF_DATA_W = 8;
  localparam int BF_ALU_W  = 16;
  localparam int BF_FRAC   = 7;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } alu_op_e;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_TW_FETCH = 4'd1,
    S_MUL_RR   = 4'd2,
    S_MUL_II   = 4'd3,
    S_SUB_R    = 4'd4,
    S_MUL_RI   = 4'd5,
    S_MUL_IR   = 4'd6,
    S_ADD_I    = 4'd7,
    S_Y_RE     = 4'd8,
    S_Z_RE     = 4'd9,
    S_Y_IM     = 4'd10,
    S_Z_IM     = 4'd11,
    S_DONE     = 4'd12
  } bf_state_e;

endpackage

// File: rtl/butterfly_scheduler.sv
// rtl/butterfly_scheduler.sv - sequences one complex butterfly through a shared external ALU
module butterfly_scheduler
  import butterfly_pkg::*;
#(
  parameter int DATA_W = BF_DATA_W,
  parameter int ALU_W  = BF_ALU_W,
  parameter int FRAC   = BF_FRAC
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_rea,
  input  logic [DATA_W-1:0] i_ima,
  input  logic [DATA_W-1:0] i_reb,
  input  logic [DATA_W-1:0] i_imb,
  input  logic [2:0]        i_tw_index,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ALU_W-1:0]  o_rey,
  output logic [ALU_W-1:0]  o_imy,
  output logic [ALU_W-1:0]  o_rez,
  output logic [ALU_W-1:0]  o_imz,
  output logic [2:0]        o_twiddle_select,
  input  logic [DATA_W-1:0] i_mux_rtw,
  input  logic [DATA_W-1:0] i_mux_itw,
  output logic [1:0]        o_opperation,
  output logic [ALU_W-1:0]  o_alu_input_1,
  output logic [ALU_W-1:0]  o_alu_input_2,
  input  logic [ALU_W-1:0]  i_alu_output
);

  localparam int EXT_W = ALU_W - DATA_W;

  bf_state_e         r_state;
  bf_state_e         w_next_state;
  alu_op_e           w_op;
  logic [ALU_W-1:0]  w_a;
  logic [ALU_W-1:0]  w_b;

  logic [DATA_W-1:0] r_rea, r_ima, r_reb, r_imb;
  logic [DATA_W-1:0] r_rtw, r_itw;
  logic [ALU_W-1:0]  r_p0, r_p1, r_wr, r_wi;
  logic [ALU_W-1:0]  r_rey, r_imy, r_rez, r_imz;
  logic [2:0]        r_tw_sel;

  logic [ALU_W-1:0]  w_reb_x, w_imb_x, w_rtw_x, w_itw_x;
  logic [ALU_W-1:0]  w_rea_sc, w_ima_sc;

  assign w_reb_x  = {{EXT_W{r_reb[DATA_W-1]}}, r_reb};
  assign w_imb_x  = {{EXT_W{r_imb[DATA_W-1]}}, r_imb};
  assign w_rtw_x  = {{EXT_W{r_rtw[DATA_W-1]}}, r_rtw};
  assign w_itw_x  = {{EXT_W{r_itw[DATA_W-1]}}, r_itw};
  // A is brought to the same Q scale as the twiddle products before add/sub
  assign w_rea_sc = {{EXT_W{r_rea[DATA_W-1]}}, r_rea} << FRAC;
  assign w_ima_sc = {{EXT_W{r_ima[DATA_W-1]}}, r_ima} << FRAC;

  always_comb begin
    w_next_state = r_state;
    w_op         = OP_MUL;
    w_a          = '0;
    w_b          = '0;
    case (r_state)
      S_IDLE:     if (i_in_valid) w_next_state = S_TW_FETCH;
      S_TW_FETCH: w_next_state = S_MUL_RR;
      S_MUL_RR: begin w_op = OP_MUL; w_a = w_rtw_x;  w_b = w_reb_x; w_next_state = S_MUL_II; end
      S_MUL_II: begin w_op = OP_MUL; w_a = w_itw_x;  w_b = w_imb_x; w_next_state = S_SUB_R;  end
      S_SUB_R:  begin w_op = OP_SUB; w_a = r_p0;     w_b = r_p1;    w_next_state = S_MUL_RI; end
      S_MUL_RI: begin w_op = OP_MUL; w_a = w_rtw_x;  w_b = w_imb_x; w_next_state = S_MUL_IR; end
      S_MUL_IR: begin w_op = OP_MUL; w_a = w_itw_x;  w_b = w_reb_x; w_next_state = S_ADD_I;  end
      S_ADD_I:  begin w_op = OP_ADD; w_a = r_p0;     w_b = r_p1;    w_next_state = S_Y_RE;   end
      S_Y_RE:   begin w_op = OP_ADD; w_a = w_rea_sc; w_b = r_wr;    w_next_state = S_Z_RE;   end
      S_Z_RE:   begin w_op = OP_SUB; w_a = w_rea_sc; w_b = r_wr;    w_next_state = S_Y_IM;   end
      S_Y_IM:   begin w_op = OP_ADD; w_a = w_ima_sc; w_b = r_wi;    w_next_state = S_Z_IM;   end
      S_Z_IM:   begin w_op = OP_SUB; w_a = w_ima_sc; w_b = r_wi;    w_next_state = S_DONE;   end
      S_DONE:     if (i_out_ready) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_rea    <= '0;
      r_ima    <= '0;
      r_reb    <= '0;
      r_imb    <= '0;
      r_rtw    <= '0;
      r_itw    <= '0;
      r_p0     <= '0;
      r_p1     <= '0;
      r_wr     <= '0;
      r_wi     <= '0;
      r_rey    <= '0;
      r_imy    <= '0;
      r_rez    <= '0;
      r_imz    <= '0;
      r_tw_sel <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: if (i_in_valid) begin
          r_rea    <= i_rea;
          r_ima    <= i_ima;
          r_reb    <= i_reb;
          r_imb    <= i_imb;
          r_tw_sel <= i_tw_index;
        end
        S_TW_FETCH: begin
          r_rtw <= i_mux_rtw;
          r_itw <= i_mux_itw;
        end
        S_MUL_RR: r_p0  <= i_alu_output;
        S_MUL_II: r_p1  <= i_alu_output;
        S_SUB_R:  r_wr  <= i_alu_output;
        S_MUL_RI: r_p0  <= i_alu_output;
        S_MUL_IR: r_p1  <= i_alu_output;
        S_ADD_I:  r_wi  <= i_alu_output;
        S_Y_RE:   r_rey <= i_alu_output;
        S_Z_RE:   r_rez <= i_alu_output;
        S_Y_IM:   r_imy <= i_alu_output;
        S_Z_IM:   r_imz <= i_alu_output;
        default: ;
      endcase
    end
  end

  assign o_in_ready       = (r_state == S_IDLE);
  assign o_out_valid      = (r_state == S_DONE);
  assign o_rey            = r_rey;
  assign o_imy            = r_imy;
  assign o_rez            = r_rez;
  assign o_imz            = r_imz;
  assign o_twiddle_select = r_tw_sel;
  assign o_opperation     = w_op;
  assign o_alu_input_1    = w_a;
  assign o_alu_input_2    = w_b;

endmodule

// File: tb/tb_butterfly_scheduler.sv
// tb/tb_butterfly_scheduler.sv - directed vector bench for butterfly_scheduler
module tb_butterfly_scheduler;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  rea, ima, reb, imb;
  logic [2:0]         tw_index;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        rey, imy, rez, imz;
  logic [2:0]         twiddle_select;
  logic [7:0]         mux_rtw, mux_itw;
  logic [1:0]         opperation;
  logic [15:0]        alu_in1, alu_in2;
  logic [15:0]        alu_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  butterfly_scheduler dut (
    .i_clk(clk), .i_reset(reset),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_rea(rea), .i_ima(ima), .i_reb(reb), .i_imb(imb),
    .i_tw_index(tw_index),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_rey(rey), .o_imy(imy), .o_rez(rez), .o_imz(imz),
    .o_twiddle_select(twiddle_select),
    .i_mux_rtw(mux_rtw), .i_mux_itw(mux_itw),
    .o_opperation(opperation),
    .o_alu_input_1(alu_in1), .o_alu_input_2(alu_in2),
    .i_alu_output(alu_out)
  );

  // Twiddle ROM: indices 0..3 are used by the vectors
  always_comb begin
    case (twiddle_select)
      3'd0:    begin mux_rtw = 8'd127;  mux_itw = 8'd0;    end
      3'd1:    begin mux_rtw = 8'd0;    mux_itw = -8'sd127; end
      3'd2:    begin mux_rtw = -8'sd128; mux_itw = 8'd127; end
      3'd3:    begin mux_rtw = 8'd90;   mux_itw = -8'sd90; end
      default: begin mux_rtw = 8'd11;   mux_itw = 8'd22;   end
    endcase
  end

  logic signed [31:0] prod;
  always_comb begin
    prod = $signed(alu_in1) * $signed(alu_in2);
    case (opperation)
      2'd0:    alu_out = prod[15:0];
      2'd1:    alu_out = alu_in1 + alu_in2;
      2'd2:    alu_out = alu_in1 - alu_in2;
      default: alu_out = 16'hDEAD;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]         idx;
    logic signed [7:0]  rea, ima, reb, imb;
    int                 rey, imy, rez, imz;
    int                 hold;
  } vec_t;

  vec_t vecs[4];
  int   exp_ops[10] = '{0, 0, 2, 0, 0, 1, 1, 2, 1, 2};

  // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
  task automatic do_bf(input vec_t v);
    logic [15:0] s_rey, s_imy, s_rez, s_imz;
    chk("in_ready_before_req", int'(in_ready), 1);
    rea = v.rea; ima = v.ima; reb = v.reb; imb = v.imb;
    tw_index = v.idx; in_valid = 1'b1;
    out_ready = (v.hold == 0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      tw_index = 3'd7;
      if (c == 1) begin
        chk("twsel_fetch", int'(twiddle_select), int'(v.idx));
        chk("op_fetch", int'(opperation), 0);
        chk("alu_in_fetch", int'(alu_in1 | alu_in2), 0);
      end
      if (c >= 2 && c <= 11) begin
        chk($sformatf("op_trace_%0d", c - 2), int'(opperation), exp_ops[c-2]);
        chk("twsel_hold", int'(twiddle_select), int'(v.idx));
        chk("in_ready_busy", int'(in_ready), 0);
      end
      chk($sformatf("out_valid_c%0d", c), int'(out_valid), (c == 12) ? 1 : 0);
    end
    chk("rey", int'($signed(rey)), v.rey);
    chk("imy", int'($signed(imy)), v.imy);
    chk("rez", int'($signed(rez)), v.rez);
    chk("imz", int'($signed(imz)), v.imz);
    chk("alu_in_done", int'(alu_in1 | alu_in2), 0);
    s_rey = rey; s_imy = imy; s_rez = rez; s_imz = imz;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_stable", int'({s_rey, s_imy, s_rez, s_imz} == {rey, imy, rez, imz}), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after", int'(in_ready), 1);
    chk("out_valid_after", int'(out_valid), 0);
  endtask

  initial begin
    vecs[0] = '{idx: 3'd0, rea: 8'sd10, ima: 8'sd0, reb: 8'sd4, imb: 8'sd0,
                rey: 1788, imy: 0, rez: 772, imz: 0, hold: 0};
    vecs[1] = '{idx: 3'd1, rea: 8'sd0, ima: 8'sd0, reb: 8'sd2, imb: 8'sd3,
                rey: 381, imy: -254, rez: -381, imz: 254, hold: 0};
    vecs[2] = '{idx: 3'd2, rea: 8'sd1, ima: 8'sd0, reb: -8'sd128, imb: -8'sd128,
                rey: -32768, imy: 128, rez: -32512, imz: -128, hold: 20};
    vecs[3] = '{idx: 3'd3, rea: -8'sd5, ima: 8'sd7, reb: 8'sd3, imb: -8'sd2,
                rey: -550, imy: 446, rez: -730, imz: 1346, hold: 0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    rea = '0; ima = '0; reb = '0; imb = '0; tw_index = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_results", int'(rey | imy | rez | imz), 0);
    chk("rst_twsel", int'(twiddle_select), 0);
    chk("rst_op", int'(opperation), 0);

    // Vectors run back-to-back: each request lands on the first IDLE cycle
    for (int i = 0; i < 4; i++) do_bf(vecs[i]);

    // Reset in the middle of a butterfly discards it
    rea = 8'sd9; ima = 8'sd9; reb = 8'sd9; imb = 8'sd9; tw_index = 3'd3; in_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_results", int'(rey | imy | rez | imz), 0);
    chk("midrst_twsel", int'(twiddle_select), 0);
    begin
      int seen = 0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("midrst_no_output", seen, 0);
    end

    do_bf(vecs[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/butterfly_scheduler.md
Name: butterfly_scheduler

Overview:
- Self-sequencing controller for one radix-2 complex butterfly: Y = A + W·B, Z = A − W·B.
- Time-multiplexes the single shared ALU (multiply/add/subtract) through 10 micro-ops, one per clock.
- Fetches the twiddle through the twiddle mux.
- Valid/ready handshakes on both sides replace manual button stepping, so a later FFT stage sequencer can drive it back-to-back.

Parameters:
- DATA_W, 8, width of signed input samples and twiddle parts (Q1.(DATA_W−1) twiddle).
- ALU_W, 16, ALU operand/result width; must equal 2·DATA_W.
- FRAC, 7, twiddle fractional bits; A operands are pre-scaled by <<< FRAC.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  butterfly request.
- in_ready  out  1  high only in IDLE.
- Rea, Ima, Reb, Imb  in  DATA_W each  signed samples A, B.
- tw_index  in  3  twiddle index, sampled on input handshake.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- Rey, Imy, Rez, Imz  out  ALU_W each  signed results, scale 2^FRAC.
- twiddle_select  out  3  to twiddle mux.
- MuxRtw, MuxItw  in  DATA_W  twiddle mux outputs, combinational from twiddle_select.
- opperation  out  2  ALU op: 0 mul, 1 add, 2 sub.
- alu_input_1, alu_input_2  out  ALU_W  ALU operands.
- alu_output  in  ALU_W  combinational ALU result.

Behaviour:
- Reset (synchronous, dominates all inputs): state IDLE; in_ready=1 after reset releases; out_valid=0; Rey/Imy/Rez/Imz=0; twiddle_select=0. All internal registers are cleared: p0, p1, wr, wi, Rtw, Itw, and the sample registers. Reset mid-operation discards the butterfly with no output.
- IDLE: in_ready=1. On in_valid: capture Rea/Ima/Reb/Imb, drive twiddle_select<=tw_index, go to TW_FETCH. If in_valid is low, stay.
- TW_FETCH: latch Rtw<=MuxRtw and Itw<=MuxItw, then go to the ALU micro-op states.
- ALU states run in order. Each captures alu_output at the end of its cycle:
  - MUL_RR: Rtw·Reb -> p0
  - MUL_II: Itw·Imb -> p1
  - SUB_R: p0 − p1 -> wr
  - MUL_RI: Rtw·Imb -> p0
  - MUL_IR: Itw·Reb -> p1
  - ADD_I: p0 + p1 -> wi
  - Y_RE: (Rea<<<FRAC) + wr -> Rey
  - Z_RE: (Rea<<<FRAC) − wr -> Rez
  - Y_IM: (Ima<<<FRAC) + wi -> Imy
  - Z_IM: (Ima<<<FRAC) − wi -> Imz, then go to DONE
- Operand width: DATA_W values are sign-extended to ALU_W before entering the ALU.
- Result width: all ALU results are taken as the low ALU_W bits, wrapping modulo 2^ALU_W. No saturation and no overflow flag.
- DONE: out_valid=1, results held stable. On out_ready go to IDLE with out_valid=0 the next cycle. While out_ready is low, hold indefinitely.
- Result registers keep their last values until the next Y_RE/Z_RE/Y_IM/Z_IM writes them. They read only as meaningful while out_valid=1.
- Latency: input handshake at cycle 0 -> out_valid at cycle 12. Throughput is one butterfly per 13 cycles with out_ready tied high.
- In IDLE, TW_FETCH and DONE: opperation=0, alu_input_1=0, alu_input_2=0.
- twiddle_select holds its value from capture until the next accepted request.
- in_valid outside IDLE is ignored; in_ready=0 in every non-IDLE state.

Decomposition:
- Package butterfly_pkg holds:
  - the ALU op enum (OP_MUL=2'd0, OP_ADD=2'd1, OP_SUB=2'd2)
  - the state enum (13 states above, 4-bit)
  - the DATA_W/ALU_W/FRAC defaults
- No sub-module. The operand mux is a single always_comb keyed on state; the sequencer is a single always_ff.

Test Plan:
- Reset, then idle: in_ready=1, out_valid=0, all results 0. Assert Reset at cycle 5 of an operation -> IDLE next cycle, no out_valid.
- W≈1 (Rtw=127, Itw=0), A=(10,0), B=(4,0) -> Rey=1788, Rez=772, Imy=0, Imz=0; out_valid exactly 12 cycles after the handshake.
- W≈−j (Rtw=0, Itw=−127), A=(0,0), B=(2,3) -> Rey=381, Imy=−254, Rez=−381, Imz=254.
- Wrap: Rtw=−128, Itw=127, A=(1,0), B=(−128,−128) -> wr=32640; Rey=0x8000 (−32768), Rez=−32512.
- Back-pressure: hold out_ready=0 for 20 cycles -> out_valid and results stable, in_ready=0. Set out_ready=1 -> in_ready=1 next cycle, and the next request is accepted.
- Op trace: check the opperation sequence 0,0,2,0,0,1,1,2,1,2 across the ALU states, and twiddle_select=tw_index from TW_FETCH onward.
